serial_shift_receiver: RTL and testbench
========================================

# serial_shift_receiver

Serial-to-parallel receiver that rebuilds WIDTH-bit words from a one-bit-per-cycle stream shifted out MSB-first or LSB-first. It sits on the receive side of the team's serial shift datapath and presents each assembled word on a valid/ready output port. A one-word holding register allows the next word to be assembled while the current word waits for the consumer.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort: discards the partial word, drops out_valid, clears overrun.
- shift_dir  in  1  0 = MSB-first (left-shift assembly), 1 = LSB-first (right-shift assembly); sampled only with the first bit of each word.
- bit_valid  in  1  bit_in is presented this cycle.
- bit_in  in  1  serial data bit.
- out_ready  in  1  consumer accepts data_out this cycle.
- data_out  out  WIDTH  assembled word; stable while out_valid=1.
- out_valid  out  1  data_out holds an unconsumed word.
- busy  out  1  a partial word is in progress (bit count != 0).
- overrun  out  1  sticky; a completed word was dropped because the holding register was full.

## Operation
- Internal state: shift register sreg[WIDTH-1:0], bit counter cnt (0..WIDTH-1), latched direction dir_q, holding register data_out, flag out_valid.
- Accepted bit: a bit is accepted on every edge with bit_valid=1 and clear=0. There is no back-pressure on the serial side.
- First bit of a word (cnt=0): dir_q <= shift_dir. This bit and all later bits of the word use the new dir_q. Changes to shift_dir mid-word are ignored.
- dir=0 assembly: sreg <= {sreg[WIDTH-2:0], bit_in}. The first bit received lands in the MSB.
- dir=1 assembly: sreg <= {bit_in, sreg[WIDTH-1:1]}. The first bit received lands in the LSB.
- Counter: increments per accepted bit. When the WIDTH-th bit is accepted (cnt=WIDTH-1), the word is complete and cnt wraps to 0.
- Word completion, evaluated on the same edge:
  - out_valid=0, or out_valid=1 with out_ready=1: data_out <= the assembled word (including the final bit) and out_valid <= 1.
  - out_valid=1 with out_ready=0: the new word is dropped, data_out is unchanged, and overrun <= 1.
- Handshake: when out_valid=1 and out_ready=1 on an edge with no word completing, out_valid <= 0. out_ready has no effect while out_valid=0.
- overrun stays set until clear or reset. Only clear and rst_n reset it.
- clear priority: clear overrides every other event in the same cycle. Its effects are cnt <= 0, out_valid <= 0, and overrun <= 0. The bit presented in that cycle is discarded. sreg, data_out, and dir_q keep their values, and their contents are don't-care until they are next written.
- busy = (cnt != 0). It is combinational from the register.
- No FSM is needed beyond the counter and out_valid. States are COLLECT (cnt) × HOLD (out_valid), and all four combinations are legal.

## Timing
- Reset values (rst_n=0, asynchronous): data_out=0, out_valid=0, busy=0, overrun=0, cnt=0, sreg=0, dir_q=0.
- Latency: if the final bit is accepted on edge N, then out_valid=1 and data_out are valid after edge N. This gives a minimum of WIDTH accepted bits from the first bit to out_valid.
- Throughput: one word per WIDTH cycles with back-to-back bits when the consumer holds out_ready=1. No bubbles are needed between words.
- Simultaneous completion and handshake: on that edge the old word is consumed, the new word loads, and out_valid stays 1.
- Reset mid-word or mid-hold: all state returns to its reset values immediately. The partial word is lost.
- Gaps in bit_valid stall assembly without loss. There is no timeout.

## Test plan
- WIDTH=4, shift_dir=0, bits 1,0,1,1 on consecutive cycles, out_ready=1 → after the 4th edge, out_valid=1 and data_out=4'b1011. out_valid drops one cycle later.
- shift_dir=1, same bits 1,0,1,1 → data_out=4'b1101. Toggling shift_dir after the 1st bit still yields 4'b1101.
- out_ready=0; send words 4'hA then 4'h5 back-to-back (MSB-first) → data_out stays 4'hA, overrun=1 after the 8th bit, and busy=0.
- out_valid=1 with 4'h3 held; raise out_ready on the same cycle the final bit of 4'hC completes → data_out=4'hC, out_valid stays 1, and overrun=0.
- Send 2 bits, then pulse clear together with a third bit_valid → busy=0 and out_valid=0. The next 4 bits 0,1,1,0 yield data_out=4'b0110.
- Assert rst_n=0 asynchronously mid-word and mid-hold → all outputs are 0 immediately, before the next clk edge. A following word assembles correctly.

Source files
------------

// File: rtl/serial_shift_receiver.sv
// ---------------------------------------------------------------------------
// serial_shift_receiver
//
// Rebuilds WIDTH-bit words from a one-bit-per-cycle serial stream. Each word
// arrives either MSB-first or LSB-first. The direction is taken from
// shift_dir with the first bit of the word. Finished words are presented on
// a valid/ready port through a one-word holding register, so the next word
// can be assembled while the consumer is still working on the current one.
// If a word completes while the holding register is still occupied and is
// not being drained, that word is dropped and the sticky overrun flag is set.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort: drops the partial word, out_valid and
//                   overrun; the bit presented in the same cycle is ignored
//   shift_dir  in   0 = MSB-first, 1 = LSB-first (sampled on the first bit)
//   bit_valid  in   bit_in carries a serial bit this cycle
//   bit_in     in   serial data bit
//   out_ready  in   consumer accepts data_out this cycle
//   data_out   out  assembled word, stable while out_valid is high
//   out_valid  out  data_out holds an unconsumed word
//   busy       out  a partial word is in progress
//   overrun    out  sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module serial_shift_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_dir,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    // The counter only needs to reach WIDTH-1 before it wraps.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Register state
    logic [WIDTH-1:0] sreg_q,      sreg_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             dir_q,       dir_d;
    logic [WIDTH-1:0] data_q,      data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q,   overrun_d;

    // Datapath helpers
    logic             accept;      // a bit is taken on this edge
    logic             first_bit;   // this bit starts a new word
    logic             last_bit;    // this bit completes the word
    logic             dir_eff;     // direction that applies to this bit
    logic [WIDTH-1:0] assembled;   // shift register after this bit

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so that
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        accept    = bit_valid && !clear;
        first_bit = (cnt_q == '0);
        last_bit  = (cnt_q == CNT_LAST);

        // The first bit of a word must already use the new direction. For
        // that reason the incoming shift_dir is bypassed rather than waiting
        // one cycle for dir_q to update.
        dir_eff = first_bit ? shift_dir : dir_q;

        if (dir_eff) begin
            assembled = {bit_in, sreg_q[WIDTH-1:1]};
        end else begin
            assembled = {sreg_q[WIDTH-2:0], bit_in};
        end

        if (clear) begin
            // clear takes priority over every other event. sreg, dir_q and
            // data_out keep their values; they are rewritten before use.
            cnt_d       = '0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (accept) begin
                sreg_d = assembled;
                dir_d  = dir_eff;
                cnt_d  = last_bit ? '0 : cnt_q + 1'b1;
            end

            if (accept && last_bit) begin
                // A word completes. It loads if the holding register is free
                // or is being drained on this same edge; otherwise it is lost.
                if (!out_valid_q || out_ready) begin
                    data_d      = assembled;
                    out_valid_d = 1'b1;
                end else begin
                    overrun_d   = 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge regardless of statement order.
    // NOTE: all of these are plain registers, not a memory array. Resetting
    // them is cheap and gives a defined data_out after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign data_out  = data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_serial_shift_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_shift_receiver
//
// Testbench for serial_shift_receiver with WIDTH=4. A reference model tracks
// the words in flight as a queue of received bits. It converts a finished
// word to its value by positional arithmetic and keeps the holding register
// and the overrun flag as plain variables. Directed scenarios are followed
// by a long randomized run.
// ---------------------------------------------------------------------------
module tb_serial_shift_receiver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         shift_dir;
    logic         bit_valid;
    logic         bit_in;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_bits[$];
    bit           m_dir;
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_over;

    serial_shift_receiver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .shift_dir (shift_dir),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Word value from the arrival order. MSB-first: bit i has weight
    // 2^(W-1-i). LSB-first: bit i has weight 2^i.
    function automatic logic [W-1:0] word_of(input bit dir);
        int unsigned v = 0;
        for (int i = 0; i < W; i++) begin
            if (m_bits[i]) v += dir ? (1 << i) : (1 << (W - 1 - i));
        end
        return W'(v);
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
    endtask

    // One clock edge of the model, using the inputs applied before the edge.
    task automatic model_step();
        bit done = 1'b0;
        if (clear) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_over  = 1'b0;
        end else begin
            if (bit_valid) begin
                if (m_bits.size() == 0) m_dir = shift_dir;
                m_bits.push_back(bit_in);
                if (m_bits.size() == W) begin
                    done = 1'b1;
                    if (!m_valid || out_ready) begin
                        m_data  = word_of(m_dir);
                        m_valid = 1'b1;
                    end else begin
                        m_over = 1'b1;
                    end
                    m_bits.delete();
                end
            end
            if (!done && m_valid && out_ready) m_valid = 1'b0;
        end
    endtask

    // Apply inputs, take one clock edge, and settle 1 time unit after it.
    task automatic drive(input logic bv, input logic b, input logic dir,
                         input logic rdy, input logic clr);
        bit_valid = bv;
        bit_in    = b;
        shift_dir = dir;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0; shift_dir = 1'b0; bit_valid = 1'b0;
        bit_in = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (data_out !== 4'h0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h valid=%b busy=%b ovr=%b required all 0",
                     data_out, out_valid, busy, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_msb_first();
        drive(1, 1, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL msb_busy: got %b required 1", busy);
        end
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        n_checks++;
        if (out_valid !== 1'b1 || data_out !== 4'b1011 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_word: got valid=%b data=%b busy=%b required 1 1011 0",
                     out_valid, data_out, busy);
        end
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL msb_consume: got valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_lsb_first();
        drive(1, 1, 1, 1, 0);
        drive(1, 0, 1, 1, 0);
        drive(1, 1, 1, 1, 0);
        drive(1, 1, 1, 1, 0);
        n_checks++;
        if (out_valid !== 1'b1 || data_out !== 4'b1101) begin
            n_fail++;
            $display("FAIL lsb_word: got valid=%b data=%b required 1 1101", out_valid, data_out);
        end
        idle(1);
        // Toggle shift_dir after the first bit; it must be ignored.
        drive(1, 1, 1, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        n_checks++;
        if (out_valid !== 1'b1 || data_out !== 4'b1101) begin
            n_fail++;
            $display("FAIL lsb_toggle: got valid=%b data=%b required 1 1101", out_valid, data_out);
        end
        idle(1);
    endtask

    task automatic test_overrun();
        logic [7:0] stream;
        stream = 8'hA5;
        for (int i = 7; i >= 0; i--) drive(1, stream[i], 0, 0, 0);
        n_checks++;
        if (data_out !== 4'hA || out_valid !== 1'b1 || overrun !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun: got data=%h valid=%b ovr=%b busy=%b required a 1 1 0",
                     data_out, out_valid, overrun, busy);
        end
        // overrun is sticky through a consume.
        idle(1);
        n_checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_sticky: got ovr=%b valid=%b required 1 0", overrun, out_valid);
        end
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL overrun_clear: got %b required 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w3, wc;
        w3 = 4'h3;
        wc = 4'hC;
        for (int i = 3; i >= 0; i--) drive(1, w3[i], 0, 0, 0);
        for (int i = 3; i >= 1; i--) drive(1, wc[i], 0, 0, 0);
        n_checks++;
        if (data_out !== 4'h3 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hold: got data=%h valid=%b required 3 1", data_out, out_valid);
        end
        drive(1, wc[0], 0, 1, 0);
        n_checks++;
        if (data_out !== 4'hC || out_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_swap: got data=%h valid=%b ovr=%b required c 1 0",
                     data_out, out_valid, overrun);
        end
        idle(1);
    endtask

    task automatic test_clear();
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 1);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_abort: got busy=%b valid=%b required 0 0", busy, out_valid);
        end
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        n_checks++;
        if (data_out !== 4'b0110 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_next: got data=%b valid=%b required 0110 1", data_out, out_valid);
        end
    endtask

    task automatic test_async_reset();
        // A word is held (from test_clear) and a new word is half-assembled.
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (data_out !== 4'h0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got data=%h valid=%b busy=%b ovr=%b required all 0",
                     data_out, out_valid, busy, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        n_checks++;
        if (data_out !== 4'b1001 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_then_word: got data=%b valid=%b required 1001 1", data_out, out_valid);
        end
        idle(1);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 3000; c++) begin
            drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 60) == 0));
            n_checks++;
            if (out_valid !== m_valid || busy !== (m_bits.size() != 0) || overrun !== m_over ||
                (m_valid && data_out !== m_data)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle %0d: got data=%h valid=%b busy=%b ovr=%b required data=%h valid=%b busy=%b ovr=%b",
                             c, data_out, out_valid, busy, overrun,
                             m_data, m_valid, m_bits.size() != 0, m_over);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overrun();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
